// File: rtl/pipeline_hazard_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller_if
// Bundles the signals that pass between the pipeline and its hazard controller.
//   master : pipeline side. Drives the hazard sources (register indices, load
//            flag, branch, dmem handshake, counter clear) and receives the
//            stage enables, flushes, status and performance counters.
//   slave  : hazard controller side. The same signals with the directions
//            reversed.
// Parameter CNT_W sets the width of the two performance counters.
// -----------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             if_id_use_rs1;
  logic             if_id_use_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_mem_read;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             clr_counters;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
           id_ex_rd, id_ex_mem_read, branch_taken, dmem_req, dmem_ready,
           clr_counters,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_flush, state, mem_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
           id_ex_rd, id_ex_mem_read, branch_taken, dmem_req, dmem_ready,
           clr_counters,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_flush, state, mem_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
// Stall and flush control for a five-stage in-order pipeline.
// The stage enables and flushes are combinational (Mealy) outputs. They are
// computed from the current FSM state and the current hazard inputs, with this
// priority: ERR > memory busy > branch taken > load-use > normal.
// A small FSM (RUN / MWAIT / ERR) tracks how long the MEM stage has been
// waiting. A wait that lasts TIMEOUT_CYCLES consecutive cycles ends in ERR,
// which is absorbing until reset.
// Ports:
//   clk   : clock; all state updates on the rising edge
//   rst_n : synchronous, active-low reset
//   hz    : slave modport of pipeline_hazard_controller_if
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipeline_hazard_controller_if.slave   hz
);

  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] MWAIT = 2'b01;
  localparam logic [1:0] ERR   = 2'b10;
  localparam int         WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]        state_q,        state_d;
  logic [WAIT_W-1:0] wait_cnt_q,     wait_cnt_d;
  logic              mem_timeout_q,  mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q,  flush_count_d;

  logic              mem_busy_s;
  logic              load_use_s;
  logic [WAIT_W-1:0] wait_next_s;
  // pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_flush
  logic [6:0]        ctrl_s;

  // Hazard detection and prioritised Mealy control outputs
  always_comb begin
    mem_busy_s = hz.dmem_req && !hz.dmem_ready;
    load_use_s = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
                 ((hz.if_id_use_rs1 && (hz.if_id_rs1 == hz.id_ex_rd)) ||
                  (hz.if_id_use_rs2 && (hz.if_id_rs2 == hz.id_ex_rd)));
    ctrl_s = 7'b1111_000;
    if (!rst_n) begin
      ctrl_s = 7'b1111_000;            // reset cycle looks like normal flow
    end else if ((state_q == ERR) || mem_busy_s) begin
      ctrl_s = 7'b0000_001;            // freeze everything, bubble into WB
    end else if (hz.branch_taken) begin
      ctrl_s = 7'b1111_110;            // squash IF/ID and ID/EX; hides load-use
    end else if (load_use_s) begin
      ctrl_s = 7'b0011_010;            // hold PC and IF/ID, one-cycle bubble in EX
    end else begin
      ctrl_s = 7'b1111_000;
    end
  end

  // Wait-counter FSM: the counter holds the number of consecutive busy cycles
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    wait_next_s = WAIT_W'(1);
    case (state_q)
      RUN: begin
        wait_next_s = WAIT_W'(1);
        if (mem_busy_s) begin
          wait_cnt_d = wait_next_s;
          state_d    = (wait_next_s >= WAIT_LIMIT) ? ERR : MWAIT;
        end else begin
          wait_cnt_d = {WAIT_W{1'b0}};
          state_d    = RUN;
        end
      end
      MWAIT: begin
        // Never exceeds WAIT_LIMIT because reaching it leaves MWAIT.
        wait_next_s = wait_cnt_q + WAIT_W'(1);
        if (mem_busy_s) begin
          wait_cnt_d = wait_next_s;
          state_d    = (wait_next_s >= WAIT_LIMIT) ? ERR : MWAIT;
        end else begin
          // ready, or the request was withdrawn: both end the wait
          wait_cnt_d = {WAIT_W{1'b0}};
          state_d    = RUN;
        end
      end
      ERR: begin
        state_d    = ERR;
        wait_cnt_d = wait_cnt_q;
      end
      default: begin
        // 2'b11 is unreachable; recover to RUN if it ever appears
        state_d    = RUN;
        wait_cnt_d = {WAIT_W{1'b0}};
      end
    endcase
    mem_timeout_d = (state_d == ERR);
  end

  // Saturating performance counters; a clear takes precedence over a count
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (hz.clr_counters) begin
      stall_cycles_d = {CNT_W{1'b0}};
      flush_count_d  = {CNT_W{1'b0}};
    end else begin
      if (!ctrl_s[6] && (stall_cycles_q != CNT_MAX)) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end else begin
        stall_cycles_d = stall_cycles_q;
      end
      if (ctrl_s[2] && (flush_count_q != CNT_MAX)) begin
        flush_count_d = flush_count_q + CNT_W'(1);
      end else begin
        flush_count_d = flush_count_q;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= {WAIT_W{1'b0}};
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= {CNT_W{1'b0}};
      flush_count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Drive the interface outputs
  always_comb begin
    hz.pc_write     = ctrl_s[6];
    hz.if_id_write  = ctrl_s[5];
    hz.id_ex_write  = ctrl_s[4];
    hz.ex_mem_write = ctrl_s[3];
    hz.if_id_flush  = ctrl_s[2];
    hz.id_ex_flush  = ctrl_s[1];
    hz.mem_wb_flush = ctrl_s[0];
    hz.state        = state_q;
    hz.mem_timeout  = mem_timeout_q;
    hz.stall_cycles = stall_cycles_q;
    hz.flush_count  = flush_count_q;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16; maximum consecutive MEM-wait cycles before the error state.
REQ-002 SHALL have parameter CNT_W, default 32; width of each performance counter.
REQ-003 SHALL have port clk, input, 1; the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset, synchronous and active-low.
REQ-005 SHALL have ports if_id_rs1 and if_id_rs2, input, 5 each; source registers of the instruction in ID.
REQ-006 SHALL have ports if_id_use_rs1 and if_id_use_rs2, input, 1 each; high when the ID instruction reads that source.
REQ-007 SHALL have ports id_ex_rd (input, 5) and id_ex_mem_read (input, 1); destination register of the instruction in EX, and a flag that it is a load.
REQ-008 SHALL have port branch_taken, input, 1; a branch or jump in EX redirects the PC this cycle.
REQ-009 SHALL have ports dmem_req and dmem_ready, input, 1 each; the MEM-stage access handshake.
REQ-010 SHALL have port clr_counters, input, 1; synchronous clear of both counters.
REQ-011 SHALL have outputs pc_write, if_id_write, id_ex_write, ex_mem_write, 1 each; per-stage register enables.
REQ-012 SHALL have outputs if_id_flush, id_ex_flush, mem_wb_flush, 1 each; insert a bubble into that stage register.
REQ-013 SHALL have outputs state (2) and mem_timeout (1); current FSM state, and a sticky timeout error flag.
REQ-014 SHALL have outputs stall_cycles and flush_count, CNT_W each; the performance counters.

Function
REQ-015 SHALL implement FSM states RUN=2'b00, MWAIT=2'b01, ERR=2'b10; 2'b11 SHALL never be entered.
REQ-016 SHALL define mem_busy = dmem_req && !dmem_ready.
REQ-017 SHALL define load_use = id_ex_mem_read && id_ex_rd!=0 && ((if_id_use_rs1 && rs1==id_ex_rd) || (if_id_use_rs2 && rs2==id_ex_rd)).
REQ-018 SHALL drive all control outputs combinationally (Mealy) from state and the current inputs, with priority ERR > mem_busy > branch_taken > load_use > normal.
REQ-019 SHALL, in normal operation, drive all four write enables to 1 and all three flushes to 0.
REQ-020 SHALL, in ERR or when mem_busy, drive all write enables to 0, mem_wb_flush=1, and the other flushes to 0.
REQ-021 SHALL, on branch_taken without mem_busy, drive all write enables to 1, if_id_flush=1, id_ex_flush=1, and mem_wb_flush=0.
REQ-022 SHALL, on load_use without branch_taken or mem_busy, drive pc_write=0, if_id_write=0, id_ex_flush=1, and all other enables to 1; this gives exactly a one-cycle bubble.
REQ-023 SHALL let branch_taken suppress load_use in the same cycle, because the ID instruction is squashed.
REQ-024 SHALL transition RUN->MWAIT when mem_busy, loading wait_cnt=1.
REQ-025 SHALL, in MWAIT: when dmem_ready=1, return to RUN, apply REQ-019..023 that cycle, and clear wait_cnt.
REQ-026 SHALL, in MWAIT with mem_busy: increment wait_cnt, and enter ERR when wait_cnt==TIMEOUT_CYCLES with mem_busy still true.
REQ-027 SHALL, in MWAIT with dmem_req dropped, treat the cycle as ready and return to RUN.
REQ-028 SHALL make ERR absorbing until reset, with mem_timeout=1 while in ERR.
REQ-029 SHALL increment stall_cycles on every cycle with pc_write=0, saturating at all-ones.
REQ-030 SHALL increment flush_count on every cycle with if_id_flush=1, saturating at all-ones.
REQ-031 SHALL give clr_counters priority over increment, so both counters read 0 on the next cycle.
REQ-032 SHALL hold wait_cnt to ceil(log2(TIMEOUT_CYCLES+1)) bits with no wrap.

Reset
REQ-033 SHALL, while rst_n=0 at a clock edge, set state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, and flush_count=0.
REQ-034 SHALL drive normal-operation control values (REQ-019) during the reset cycle.
REQ-035 SHALL let reset asserted in MWAIT or ERR return to RUN on the next edge, regardless of dmem_ready.

Verification
REQ-036 SHALL cover load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rs1=5, use_rs1=1 -> pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles increments by 1.
REQ-037 SHALL cover branch plus load-use in the same cycle: if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count +1, stall_cycles unchanged.
REQ-038 SHALL cover a memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 -> state MWAIT for 3 cycles then RUN; writes 0 and mem_wb_flush=1 on those 3 cycles; stall_cycles +3.
REQ-039 SHALL cover timeout: dmem_ready held 0 for 16 cycles -> state=ERR, mem_timeout=1, all enables 0 until rst_n=0; RUN after reset.
REQ-040 SHALL cover x0 and unused sources: id_ex_rd=0 with rs1=0, and id_ex_rd=7 with rs2=7 but use_rs2=0 -> no stall in either case.
REQ-041 SHALL cover counter saturation and clear: CNT_W=4, 20 stall cycles -> stall_cycles=15; clr_counters=1 -> 0 on the next cycle.
